mem_arbiter: RTL

Shares the single memory port between the instruction cache (line refills) and the data cache (line refills and writebacks). It serialises requests as one outstanding transaction at a time, routes each memory response back to its owner, and buffers the returned line until the owner accepts it. The block sits between the `icache`/`dcache` miss interfaces and the memory model or bus bridge.

---
 rtl/mem_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Serialises icache refills and dcache refills/writebacks onto one memory port.
// Define MEM_ARBITER_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise dcache wins ties.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ic_req_valid_i,
  output logic                  ic_req_ready_o,
  input  logic [ADDR_WIDTH-1:0] ic_addr_i,
  output logic                  ic_rsp_valid_o,
  input  logic                  ic_rsp_ready_i,
  output logic [LINE_WIDTH-1:0] ic_rsp_data_o,
  output logic [ADDR_WIDTH-1:0] ic_rsp_addr_o,
  input  logic                  dc_req_valid_i,
  output logic                  dc_req_ready_o,
  input  logic [ADDR_WIDTH-1:0] dc_addr_i,
  input  logic                  dc_we_i,
  input  logic [LINE_WIDTH-1:0] dc_wdata_i,
  output logic                  dc_rsp_valid_o,
  input  logic                  dc_rsp_ready_i,
  output logic [LINE_WIDTH-1:0] dc_rsp_data_o,
  output logic [ADDR_WIDTH-1:0] dc_rsp_addr_o,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [LINE_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_rsp_valid_i,
  output logic                  mem_rsp_ready_o,
  input  logic [LINE_WIDTH-1:0] mem_rsp_data_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  localparam logic OWN_IC = 1'b0;
  localparam logic OWN_DC = 1'b1;

  state_t                state;
  logic                  owner;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] wdata_q;
  logic [LINE_WIDTH-1:0] line_q;
  logic                  prefer_dc;
  logic                  grant_ic;
  logic                  grant_dc;
  logic                  accept;
  logic                  rsp_taken;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  logic last_grant;
  assign prefer_dc = (last_grant == OWN_IC);
`else
  assign prefer_dc = 1'b1;
`endif

  // Ready is gated by reset so no handshake can be seen while reset is asserted.
  always_comb begin
    grant_dc = 1'b0;
    grant_ic = 1'b0;
    if (state == IDLE && !rst_i) begin
      grant_dc = dc_req_valid_i && (!ic_req_valid_i || prefer_dc);
      grant_ic = ic_req_valid_i && !grant_dc;
    end
  end

  assign accept    = grant_ic | grant_dc;
  assign rsp_taken = (owner == OWN_IC) ? ic_rsp_ready_i : dc_rsp_ready_i;

  assign ic_req_ready_o = grant_ic;
  assign dc_req_ready_o = grant_dc;
  assign mem_addr_o     = addr_q;
  assign mem_wdata_o    = wdata_q;
  assign ic_rsp_addr_o  = addr_q;
  assign dc_rsp_addr_o  = addr_q;
  assign ic_rsp_data_o  = line_q;
  assign dc_rsp_data_o  = line_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state           <= IDLE;
      owner           <= OWN_IC;
      addr_q          <= '0;
      wdata_q         <= '0;
      line_q          <= '0;
      mem_req_valid_o <= 1'b0;
      mem_we_o        <= 1'b0;
      mem_rsp_ready_o <= 1'b0;
      ic_rsp_valid_o  <= 1'b0;
      dc_rsp_valid_o  <= 1'b0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      last_grant      <= OWN_IC;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            owner           <= grant_dc;
            addr_q          <= grant_dc ? dc_addr_i : ic_addr_i;
            wdata_q         <= grant_dc ? dc_wdata_i : '0;
            mem_we_o        <= grant_dc && dc_we_i;
            mem_req_valid_o <= 1'b1;
            state           <= REQ;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            last_grant      <= grant_dc;
`endif
          end
        end
        REQ: begin
          if (mem_req_ready_i) begin
            mem_req_valid_o <= 1'b0;
            mem_we_o        <= 1'b0;
            mem_rsp_ready_o <= 1'b1;
            state           <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rsp_valid_i) begin
            line_q          <= mem_rsp_data_i;
            mem_rsp_ready_o <= 1'b0;
            ic_rsp_valid_o  <= (owner == OWN_IC);
            dc_rsp_valid_o  <= (owner == OWN_DC);
            state           <= RESP;
          end
        end
        RESP: begin
          if (rsp_taken) begin
            ic_rsp_valid_o <= 1'b0;
            dc_rsp_valid_o <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
